// File: rtl/buffer_pkg.sv
// rtl/buffer_pkg.sv - shared constants, pointer-width helper and depth check macro for param_buffer_fifo
`define BUF_CHECK_DEPTH(d) \
    if (((d) < 2) || (((d) & ((d) - 1)) != 0)) begin : g_bad_depth \
        $error("DEPTH must be a power of two and >= 2"); \
    end

package buffer_pkg;
    localparam int DEF_WIDTH = 8;
    localparam int DEF_DEPTH = 8;

    // Extra MSB is the wrap bit that separates full from empty.
    function automatic int ptr_w(input int depth);
        return $clog2(depth) + 1;
    endfunction
endpackage

// File: rtl/buffer_mem.sv
// rtl/buffer_mem.sv - DEPTH x WIDTH register array, one sync write port, one async read port
module buffer_mem #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [WIDTH-1:0]         rdata
);
    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    assign rdata = r_mem[raddr];
endmodule

// File: rtl/param_buffer_fifo.sv
// rtl/param_buffer_fifo.sv - show-ahead valid/ready FIFO; BUF_LEVEL_EN adds level and almost_full outputs
module param_buffer_fifo
    import buffer_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int DEPTH     = DEF_DEPTH,
    parameter int AF_THRESH = DEPTH - 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_data
`ifdef BUF_LEVEL_EN
    ,
    output logic [$clog2(DEPTH):0] level,
    output logic                   almost_full
`endif
);
    localparam int PW = ptr_w(DEPTH);
    localparam int AW = PW - 1;

    `BUF_CHECK_DEPTH(DEPTH)

    if ((WIDTH < 1) || (AF_THRESH < 0) || (AF_THRESH > DEPTH)) begin : g_bad_params
        $error("WIDTH must be >= 1 and AF_THRESH within 0..DEPTH");
    end

    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic          w_empty;
    logic          w_full;
    logic          w_wr_fire;
    logic          w_rd_fire;

    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) && (r_wr_ptr[AW] != r_rd_ptr[AW]);

    // Both handshake outputs depend on registered pointers only.
    assign in_ready  = !w_full;
    assign out_valid = !w_empty;
    assign w_wr_fire = in_valid && !w_full;
    assign w_rd_fire = out_ready && !w_empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_wr_fire) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_rd_fire) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

    buffer_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk   (clk),
        .we    (w_wr_fire),
        .waddr (r_wr_ptr[AW-1:0]),
        .wdata (in_data),
        .raddr (r_rd_ptr[AW-1:0]),
        .rdata (out_data)
    );

`ifdef BUF_LEVEL_EN
    logic [PW-1:0] w_level;

    assign w_level     = r_wr_ptr - r_rd_ptr;
    assign level       = w_level;
    assign almost_full = (w_level >= PW'(AF_THRESH));
`endif
endmodule
